// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - shared constants and helpers for the pipeline stall controller
//
// Purpose: latency constants for the mult/div unit, the "operand not read"
//          Tuse encoding, and counter widths shared by the top and sub-module.
package pipe_stall_ctrl_pkg;

    localparam int         MULT_CYCLES = 5;
    localparam int         DIV_CYCLES  = 10;
    localparam logic [1:0] TUSE_NONE   = 2'd3;
    localparam int         STALL_CNT_W = 16;
    localparam int         MD_CNT_W    = 4;

    // Busy length loaded into the mult/div counter when an operation starts.
    function automatic logic [MD_CNT_W-1:0] md_load(input logic is_div);
        return is_div ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_md_busy_counter.sv
// rtl/pipe_stall_ctrl_md_busy_counter.sv - mult/div occupancy down-counter
//
// Purpose: models the latency of the iterative mult/div unit. A start seen
//          while idle loads the operation length; busy is high while the
//          count is nonzero.
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-high reset
//   start   in   mult/div instruction in E this cycle
//   is_div  in   with start: 1 = div/divu, 0 = mult/multu
//   busy    out  unit occupied (flop-derived only)
module md_busy_counter
    import pipe_stall_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    logic [MD_CNT_W-1:0] cnt_q;
    logic [MD_CNT_W-1:0] cnt_d;

    // A start arriving while the count is still running is a protocol
    // violation; it is dropped so the running operation keeps its timing.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else if (start) begin
            cnt_d = md_load(is_div);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - D-stage hazard detection and stall generation
//
// Purpose: detects read-after-write hazards that forwarding cannot cover and
//          mult/div structural hazards, freezes PC and D, bubbles E, and counts
//          stalled cycles with a saturating counter.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   rs_D, rt_D                 source registers of the D instruction
//   Tuse_rs_D, Tuse_rt_D       cycles until each source is needed (3 = unused)
//   md_D                       D instruction uses the mult/div unit
//   RegWrite_E, A3_E, Tnew_E   E-stage producer
//   RegWrite_M, A3_M, Tnew_M   M-stage producer
//   start_E, is_div_E          mult/div operation launching in E
//   en_PC, en_D, clr_E         pipeline register controls
//   busy                       mult/div unit occupied
//   stall_cnt                  saturating stalled-cycle count
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             rs_D,
    input  logic [4:0]             rt_D,
    input  logic [1:0]             Tuse_rs_D,
    input  logic [1:0]             Tuse_rt_D,
    input  logic                   md_D,
    input  logic                   RegWrite_E,
    input  logic [4:0]             A3_E,
    input  logic [1:0]             Tnew_E,
    input  logic                   RegWrite_M,
    input  logic [4:0]             A3_M,
    input  logic [1:0]             Tnew_M,
    input  logic                   start_E,
    input  logic                   is_div_E,
    output logic                   en_PC,
    output logic                   en_D,
    output logic                   clr_E,
    output logic                   busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic                   md_busy;
    logic                   data_stall;
    logic                   md_stall;
    logic                   stall;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    md_busy_counter u_md_busy_counter (
        .clk    (clk),
        .reset  (reset),
        .start  (start_E),
        .is_div (is_div_E),
        .busy   (md_busy)
    );

    // A stall is needed only when the value is required before the producer
    // can forward it. $zero is never a real dependency.
    function automatic logic raw_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic       we,
        input logic [4:0] dst,
        input logic [1:0] tnew
    );
        return (tuse != TUSE_NONE) && we && (dst != 5'd0) &&
               (dst == src) && (tuse < tnew);
    endfunction

    always_comb begin
        data_stall = 1'b0;
        md_stall   = 1'b0;
        stall      = 1'b0;

        data_stall = raw_hazard(rs_D, Tuse_rs_D, RegWrite_E, A3_E, Tnew_E) ||
                     raw_hazard(rs_D, Tuse_rs_D, RegWrite_M, A3_M, Tnew_M) ||
                     raw_hazard(rt_D, Tuse_rt_D, RegWrite_E, A3_E, Tnew_E) ||
                     raw_hazard(rt_D, Tuse_rt_D, RegWrite_M, A3_M, Tnew_M);

        // start_E covers the launch cycle, before the counter reports busy.
        md_stall = md_D && (md_busy || start_E);
        stall    = data_stall || md_stall;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign en_PC     = ~stall;
    assign en_D      = ~stall;
    assign clr_E     = stall;
    assign busy      = md_busy;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed:
  clk  in  1  rising-edge clock
  reset  in  1  asynchronous active-high reset
REQ-002 The block SHALL have these hazard-detection ports:
  rs_D  in  5  rs field of instruction in D
  rt_D  in  5  rt field of instruction in D
  Tuse_rs_D  in  2  cycles until D instruction needs rs; 3 = not read
  Tuse_rt_D  in  2  cycles until D instruction needs rt; 3 = not read
  md_D  in  1  D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
  RegWrite_E  in  1  E instruction writes GPR
  A3_E  in  5  E destination register
  Tnew_E  in  2  cycles until E result is forwardable
  RegWrite_M  in  1  M instruction writes GPR
  A3_M  in  5  M destination register
  Tnew_M  in  2  cycles until M result is forwardable
REQ-003 The block SHALL have these mult/div sequencing ports:
  start_E  in  1  mult/div instruction in E this cycle
  is_div_E  in  1  with start_E: 1 = div/divu, 0 = mult/multu
REQ-004 The block SHALL have these outputs:
  en_PC  out  1  PC write enable
  en_D  out  1  D-stage register write enable
  clr_E  out  1  synchronous bubble into E-stage register
  busy  out  1  mult/div unit occupied
  stall_cnt  out  16  saturating count of stalled cycles

Function
REQ-005 Any hazard on rs SHALL be flagged when Tuse_rs_D < Tnew_E, RegWrite_E=1, A3_E!=0 and A3_E==rs_D; the same SHALL hold with A3_M/Tnew_M/RegWrite_M; rt SHALL be treated identically.
REQ-006 Tuse=3 SHALL never flag a hazard; register 0 SHALL never flag a hazard.
REQ-007 md_stall SHALL be md_D AND (busy OR start_E).
REQ-008 stall SHALL be data_stall OR md_stall, combinational within the cycle.
REQ-009 en_PC and en_D SHALL both equal NOT stall; clr_E SHALL equal stall.
REQ-010 A 4-bit down-counter cnt SHALL load 5 (mult) or 10 (div) at the clock edge where start_E=1 and cnt=0.
REQ-011 cnt SHALL decrement by 1 per cycle while nonzero; busy SHALL be (cnt!=0), registered-derived, with no combinational path from start_E.
REQ-012 busy SHALL be high for exactly 5 or 10 cycles after the start edge.
REQ-013 If start_E=1 while cnt!=0, the protocol is violated; the block SHALL ignore it and continue decrementing.
REQ-014 stall_cnt SHALL increment on every clock where stall=1 and SHALL hold at 16'hFFFF without wrapping.
REQ-015 Simultaneous data_stall and md_stall SHALL count as one stalled cycle.

Reset
REQ-016 When reset is asserted, cnt, busy and stall_cnt SHALL clear to 0 immediately, without waiting for clk, including in the middle of a mult/div sequence.
REQ-017 During reset, en_PC, en_D and clr_E SHALL follow the combinational equations using busy=0.
REQ-018 Deasserting reset SHALL clear no state beyond that listed in REQ-016.

Structure
REQ-019 The shared package SHALL hold MULT_CYCLES=5, DIV_CYCLES=10, TUSE_NONE=2'd3 and STALL_CNT_W=16.
REQ-020 The cnt/busy logic SHALL be one sub-module, md_busy_counter (ports clk, reset, start, is_div, busy); the hazard compare SHALL stay in the top level.

Verification
REQ-021 The bench SHALL drive RegWrite_E=1, A3_E=8, Tnew_E=2, rs_D=8, Tuse_rs_D=0, and require stall=1, en_PC=0, clr_E=1; it SHALL then change Tnew_E to 0 and require stall=0.
REQ-022 The bench SHALL drive A3_M=0, RegWrite_M=1, Tnew_M=1, rt_D=0, Tuse_rt_D=0, and require stall=0; it SHALL then drive Tuse_rt_D=3 with A3_M=rt_D=9 and require stall=0.
REQ-023 The bench SHALL pulse start_E=1, is_div_E=0 for one cycle, and require busy=1 for exactly 5 cycles; with md_D=1 held throughout, stall=1 SHALL occur in the start cycle plus 5 busy cycles.
REQ-024 The bench SHALL start a div, assert reset asynchronously 3 cycles later in mid-cycle, and require busy=0 and stall_cnt=0 before the next clk edge.
REQ-025 The bench SHALL hold stall=1 for 70000 cycles and require stall_cnt=16'hFFFF with no wrap.
REQ-026 The bench SHALL apply start_E=1 while busy with cnt=4, and require the remaining busy length to be 4 cycles (no reload).
